// File: rtl/uart_pkg.sv
// Shared encodings for the UART receiver: parity modes, FSM states and bit-period sampling points.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int         SUB_TICKS = 8;
    localparam logic [2:0] SAMPLE_A  = 3'd3;
    localparam logic [2:0] SAMPLE_B  = 3'd4;
    localparam logic [2:0] SAMPLE_C  = 3'd5;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Generic synchronous FIFO; head word is presented combinationally and reads as zero when empty.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH[AW:0]);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver (8 sub-ticks per bit, 2-of-3 majority) feeding an AXI-stream FIFO.
// Latency: character written at the final stop-bit mid-sample, tvalid one cycle later.
// Backpressure: tready=0 lets the FIFO fill; a character arriving to a full FIFO is dropped with overrun_error.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    input  logic [15:0]                   prescale,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          busy,
    output logic                          overrun_error,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    rx_state_e              state;
    rx_state_e              state_nxt;
    logic                   rxd_s1;
    logic                   rxd_s2;
    logic                   rxd_d;
    logic                   fall;
    logic [15:0]            ps_q;
    logic [15:0]            ps_last;
    parity_mode_e           par_q;
    logic                   stop2_q;
    logic [15:0]            sub_cnt;
    logic [2:0]             sub_tick;
    logic [1:0]             samp;
    logic [3:0]             bit_idx;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   par_bad;
    logic                   frame_bad;
    logic                   stop_idx;
    logic                   parity_en;
    logic                   last_stop;
    logic                   tick_start;
    logic                   mid_pt;
    logic                   bit_end;
    logic                   bit_val;
    logic                   start_det;
    logic                   push_req;
    logic                   frame_err_c;
    logic                   parity_err_c;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign fall       = rxd_d & ~rxd_s2;
    assign ps_last    = ps_q - 16'd1;
    assign parity_en  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign last_stop  = ~stop2_q | stop_idx;
    assign tick_start = (state != IDLE) && (sub_cnt == '0);
    assign mid_pt     = tick_start && (sub_tick == SAMPLE_C);
    assign bit_end    = (sub_tick == 3'(SUB_TICKS - 1)) && (sub_cnt == ps_last);
    // Third sample is taken live so the bit is resolved in the same cycle as the mid-sample.
    assign bit_val    = maj3(samp[0], samp[1], rxd_s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start_det    = 1'b0;
        push_req     = 1'b0;
        frame_err_c  = 1'b0;
        parity_err_c = 1'b0;
        case (state)
            IDLE: begin
                if (fall && (prescale != 16'd0)) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (mid_pt && bit_val) begin
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 4'(DATA_WIDTH - 1))) begin
                    state_nxt = parity_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (mid_pt && last_stop) begin
                    frame_err_c  = ~bit_val | frame_bad;
                    parity_err_c = par_bad;
                    push_req     = bit_val & ~frame_bad & ~par_bad;
                end
                if (bit_end && last_stop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q      <= '0;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            sub_cnt   <= '0;
            sub_tick  <= '0;
            samp      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_bad   <= 1'b0;
            frame_bad <= 1'b0;
            stop_idx  <= 1'b0;
        end else begin
            if (start_det) begin
                ps_q      <= prescale;
                par_q     <= parity_mode_e'(parity_mode);
                stop2_q   <= stop_bits;
                bit_idx   <= '0;
                par_bad   <= 1'b0;
                frame_bad <= 1'b0;
                stop_idx  <= 1'b0;
            end
            if ((state == IDLE) || (state_nxt == IDLE)) begin
                sub_cnt  <= '0;
                sub_tick <= '0;
            end else if (sub_cnt == ps_last) begin
                sub_cnt  <= '0;
                sub_tick <= sub_tick + 3'd1;
            end else begin
                sub_cnt  <= sub_cnt + 16'd1;
            end
            if (tick_start && (sub_tick == SAMPLE_A)) begin
                samp[0] <= rxd_s2;
            end
            if (tick_start && (sub_tick == SAMPLE_B)) begin
                samp[1] <= rxd_s2;
            end
            if ((state == DATA) && mid_pt) begin
                shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
            end
            if ((state == DATA) && bit_end) begin
                bit_idx <= bit_idx + 4'd1;
            end
            if ((state == PARITY) && mid_pt) begin
                par_bad <= ((^shreg) ^ bit_val) != (par_q == PAR_ODD);
            end
            if ((state == STOP) && mid_pt && !bit_val) begin
                frame_bad <= 1'b1;
            end
            if ((state == STOP) && bit_end) begin
                stop_idx <= 1'b1;
            end
        end
    end

    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid = ~fifo_empty;
    assign busy          = (state != IDLE);
    assign frame_error   = frame_err_c;
    assign parity_error  = parity_err_c;
    assign overrun_error = push_req & fifo_full & ~pop;

    rx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_req),
        .push_dat (shreg),
        .pop      (pop),
        .head_dat (m_axis_tdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomized and directed checks of uart_rx_param against a frame-level reference model.
module tb_uart_rx_param;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic [15:0]   prescale = 16'd4;
    logic [1:0]    parity_mode = 2'b00;
    logic          stop_bits = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          busy;
    logic          overrun_error;
    logic          frame_error;
    logic          parity_error;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .prescale      (prescale),
        .parity_mode   (parity_mode),
        .stop_bits     (stop_bits),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
        .fifo_count    (fifo_count)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observed stream: popped characters and pulse-cycle counts.
    logic [DW-1:0] rx_q[$];
    int            tv_cyc;
    int            ovr_cnt;
    int            frm_cnt;
    int            par_cnt;
    int            max_cnt;
    bit            busy_seen;

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
            if (m_axis_tvalid) tv_cyc++;
            ovr_cnt += int'(overrun_error);
            frm_cnt += int'(frame_error);
            par_cnt += int'(parity_error);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic clear_obs();
        rx_q.delete();
        tv_cyc    = 0;
        ovr_cnt   = 0;
        frm_cnt   = 0;
        par_cnt   = 0;
        max_cnt   = 0;
        busy_seen = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (int'(prescale) * 8) @(negedge clk);
    endtask

    // Line-level frame generator: bits LSB first, optional parity, one or two stop bits.
    task automatic send_frame(input logic [DW-1:0] d, input bit par_flip, input bit [1:0] stop_bad);
        logic par;
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (parity_mode == 2'b01 || parity_mode == 2'b10) begin
            par = (^d) ^ (parity_mode == 2'b10) ^ par_flip;
            drive_bit(par);
        end
        drive_bit(~stop_bad[0]);
        if (stop_bits) drive_bit(~stop_bad[1]);
        rxd = 1'b1;
        repeat (int'(prescale) * 8) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] d;
        bit            flip;
        bit [1:0]      sbad;
        bit            e_par;
        bit            e_frm;
        bit            accept;

        clear_obs();
        #22;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_errs", {overrun_error, frame_error, parity_error}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte, free-flowing consumer
        prescale = 16'd6; parity_mode = 2'b00; stop_bits = 1'b0; m_axis_tready = 1'b1;
        clear_obs();
        send_frame(8'hA5, 1'b0, 2'b00);
        chk("a5_n", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("a5_dat", rx_q.pop_front(), 8'hA5);
        chk("a5_tv_cyc", tv_cyc, 1);
        chk("a5_errs", ovr_cnt + frm_cnt + par_cnt, 0);

        // Fill FIFO with consumer stalled, fifth byte overruns
        prescale = 16'd3; m_axis_tready = 1'b0;
        clear_obs();
        for (int i = 1; i <= 4; i++) send_frame(DW'(i), 1'b0, 2'b00);
        chk("ovr_cnt4", fifo_count, 4);
        chk("ovr_none4", ovr_cnt, 0);
        send_frame(8'h05, 1'b0, 2'b00);
        chk("ovr_pulse", ovr_cnt, 1);
        chk("ovr_keep", fifo_count, 4);
        chk("ovr_head", m_axis_tdata, 8'h01);
        ovr_cnt = 0;
        m_axis_tready = 1'b1;
        repeat (12) @(negedge clk);
        chk("ovr_rd_n", rx_q.size(), 4);
        for (int i = 1; i <= 4; i++) begin
            if (rx_q.size() > 0) chk("ovr_rd_dat", rx_q.pop_front(), i);
        end
        chk("ovr_rd_quiet", ovr_cnt, 0);
        chk("ovr_drained", fifo_count, 0);

        // Even parity: 0x03 needs parity bit 0
        parity_mode = 2'b01;
        clear_obs();
        send_frame(8'h03, 1'b1, 2'b00);
        chk("par_bad_pulse", par_cnt, 1);
        chk("par_bad_nowr", max_cnt, 0);
        chk("par_bad_frm", frm_cnt, 0);
        clear_obs();
        send_frame(8'h03, 1'b0, 2'b00);
        chk("par_ok_pulse", par_cnt, 0);
        chk("par_ok_n", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("par_ok_dat", rx_q.pop_front(), 8'h03);

        // Two stop bits, second one low
        parity_mode = 2'b00; stop_bits = 1'b1;
        clear_obs();
        send_frame(8'h5A, 1'b0, 2'b10);
        chk("frm_pulse", frm_cnt, 1);
        chk("frm_nowr", max_cnt, 0);
        chk("frm_n", rx_q.size(), 0);
        stop_bits = 1'b0;

        // One-clock glitch on the line
        prescale = 16'd4;
        clear_obs();
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (80) @(negedge clk);
        chk("glitch_seen", busy_seen, 1);
        chk("glitch_busy", busy, 0);
        chk("glitch_nowr", max_cnt, 0);
        chk("glitch_pulses", ovr_cnt + frm_cnt + par_cnt, 0);

        // Reset mid-character with a stale byte still queued
        m_axis_tready = 1'b0;
        clear_obs();
        send_frame(8'h77, 1'b0, 2'b00);
        chk("mid_pre_cnt", fifo_count, 1);
        rxd = 1'b0;
        repeat (32) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_pre_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_tdata", m_axis_tdata, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_errs", {overrun_error, frame_error, parity_error}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        repeat (300) @(negedge clk);
        chk("mid_post_busy", busy, 0);
        chk("mid_post_n", rx_q.size(), 0);
        clear_obs();
        send_frame(8'h3C, 1'b0, 2'b00);
        chk("mid_3c_n", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("mid_3c_dat", rx_q.pop_front(), 8'h3C);

        // Randomized frames vs frame-level model
        for (int n = 0; n < 24; n++) begin
            d           = DW'($urandom_range(0, 255));
            parity_mode = 2'($urandom_range(0, 3));
            stop_bits   = 1'($urandom_range(0, 1));
            prescale    = 16'($urandom_range(2, 5));
            flip        = ($urandom_range(0, 3) == 0);
            sbad        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            e_par  = ((parity_mode == 2'b01) || (parity_mode == 2'b10)) && flip;
            e_frm  = sbad[0] || (stop_bits && sbad[1]);
            accept = !e_par && !e_frm;
            clear_obs();
            send_frame(d, flip, sbad);
            chk("rnd_par", par_cnt, e_par);
            chk("rnd_frm", frm_cnt, e_frm);
            chk("rnd_ovr", ovr_cnt, 0);
            chk("rnd_n", rx_q.size(), accept);
            if (accept && rx_q.size() > 0) chk("rnd_dat", rx_q.pop_front(), d);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
